// File: rtl/hello_arbiter.sv
// hello_arbiter: merges three HELLO AXI-Stream sources into one registered
// output stream, round-robin at packet granularity, source index on TID.
module hello_arbiter #(
    parameter int MAX_BEATS = 34,
    parameter int CNT_W     = 6
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESET,
    input  logic        S0_AXIS_TVALID,
    output logic        S0_AXIS_TREADY,
    input  logic [63:0] S0_AXIS_TDATA,
    input  logic        S0_AXIS_TLAST,
    input  logic [31:0] S0_AXIS_TUSER,
    input  logic        S1_AXIS_TVALID,
    output logic        S1_AXIS_TREADY,
    input  logic [63:0] S1_AXIS_TDATA,
    input  logic        S1_AXIS_TLAST,
    input  logic [31:0] S1_AXIS_TUSER,
    input  logic        S2_AXIS_TVALID,
    output logic        S2_AXIS_TREADY,
    input  logic [63:0] S2_AXIS_TDATA,
    input  logic        S2_AXIS_TLAST,
    input  logic [31:0] S2_AXIS_TUSER,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [63:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic [31:0] M_AXIS_TUSER,
    output logic [1:0]  M_AXIS_TID,
    input  logic [2:0]  src_enable,
    output logic        oversize_err,
    output logic        grant_active
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_LEGAL = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    state_t           state_next;
    logic [1:0]       grant;
    logic [1:0]       grant_next;
    logic [1:0]       last_grant;
    logic [1:0]       last_grant_next;
    logic [1:0]       pick;
    logic [1:0]       scan;
    logic             found;
    logic [2:0]       req;
    logic             g_valid;
    logic             g_last;
    logic [63:0]      g_data;
    logic [31:0]      g_user;
    logic             s_rdy;
    logic             s_xfr;
    logic             m_xfr;
    logic             out_full;
    logic [CNT_W-1:0] beat_cnt;

    assign req = {S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID}
               & src_enable;

    // Select the beat presented by the granted source
    always_comb begin
        g_valid = S0_AXIS_TVALID;
        g_last  = S0_AXIS_TLAST;
        g_data  = S0_AXIS_TDATA;
        g_user  = S0_AXIS_TUSER;
        case (grant)
            2'd1: begin
                g_valid = S1_AXIS_TVALID;
                g_last  = S1_AXIS_TLAST;
                g_data  = S1_AXIS_TDATA;
                g_user  = S1_AXIS_TUSER;
            end
            2'd2: begin
                g_valid = S2_AXIS_TVALID;
                g_last  = S2_AXIS_TLAST;
                g_data  = S2_AXIS_TDATA;
                g_user  = S2_AXIS_TUSER;
            end
            default: ;
        endcase
    end

    assign m_xfr = out_full & M_AXIS_TREADY;
    assign s_rdy = (state == BUSY) & (~out_full | m_xfr);
    assign s_xfr = s_rdy & g_valid;

    assign S0_AXIS_TREADY = s_rdy & (grant == 2'd0);
    assign S1_AXIS_TREADY = s_rdy & (grant == 2'd1);
    assign S2_AXIS_TREADY = s_rdy & (grant == 2'd2);

    assign M_AXIS_TVALID = out_full;
    assign grant_active  = (state == BUSY);

    // Round-robin search starting just after the last granted source
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        scan  = last_grant;
        for (int k = 0; k < 3; k++) begin
            scan = (scan == 2'd2) ? 2'd0 : scan + 2'd1;
            if (!found && req[scan]) begin
                pick  = scan;
                found = 1'b1;
            end
        end
    end

    // Next-state logic: grant in IDLE, release on accepted TLAST
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next      = BUSY;
                    grant_next      = pick;
                    last_grant_next = pick;
                end
            end
            BUSY: begin
                if (s_xfr && g_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd2;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

    // Beat counter per packet and sticky oversize flag
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            beat_cnt     <= '0;
            oversize_err <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                beat_cnt <= '0;
            end else if (s_xfr && beat_cnt != CNT_MAX) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (s_xfr && !g_last && beat_cnt == LAST_LEGAL) begin
                oversize_err <= 1'b1;
            end
        end
    end

    // Single-stage output register; reloads when drained and refilled
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            out_full     <= 1'b0;
            M_AXIS_TDATA <= '0;
            M_AXIS_TLAST <= 1'b0;
            M_AXIS_TUSER <= '0;
            M_AXIS_TID   <= 2'd0;
        end else if (s_xfr) begin
            out_full     <= 1'b1;
            M_AXIS_TDATA <= g_data;
            M_AXIS_TLAST <= g_last;
            M_AXIS_TUSER <= g_user;
            M_AXIS_TID   <= grant;
        end else if (m_xfr) begin
            out_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hello_arbiter.sv
// tb_hello_arbiter: randomized and directed checks of hello_arbiter
// against a packet-level round-robin model.
module tb_hello_arbiter;

    typedef struct packed {
        logic [63:0] d;
        logic [31:0] u;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [63:0] d;
        logic [31:0] u;
        logic        l;
        logic [1:0]  t;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  sv = '0;
    logic [2:0]  sl = '0;
    logic [63:0] sd [3];
    logic [31:0] su [3];
    logic        mr = 1'b0;
    logic [2:0]  en = 3'b111;
    wire         sr0, sr1, sr2;
    wire  [2:0]  sr = {sr2, sr1, sr0};
    wire         mv, ml, ovf, gact;
    wire  [63:0] md;
    wire  [31:0] mu;
    wire  [1:0]  mt;

    beat_t sq [3][$];
    beat_t ref_q [3][$];
    obs_t  obs [$];
    obs_t  exp_q [$];
    logic [2:0] hold = '0;
    int vprob  = 100;
    int m_mode = 0;
    int tests  = 0;
    int fails  = 0;

    hello_arbiter dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S0_AXIS_TVALID(sv[0]), .S0_AXIS_TREADY(sr0),
        .S0_AXIS_TDATA(sd[0]), .S0_AXIS_TLAST(sl[0]),
        .S0_AXIS_TUSER(su[0]),
        .S1_AXIS_TVALID(sv[1]), .S1_AXIS_TREADY(sr1),
        .S1_AXIS_TDATA(sd[1]), .S1_AXIS_TLAST(sl[1]),
        .S1_AXIS_TUSER(su[1]),
        .S2_AXIS_TVALID(sv[2]), .S2_AXIS_TREADY(sr2),
        .S2_AXIS_TDATA(sd[2]), .S2_AXIS_TLAST(sl[2]),
        .S2_AXIS_TUSER(su[2]),
        .M_AXIS_TVALID(mv), .M_AXIS_TREADY(mr),
        .M_AXIS_TDATA(md), .M_AXIS_TLAST(ml),
        .M_AXIS_TUSER(mu), .M_AXIS_TID(mt),
        .src_enable(en), .oversize_err(ovf),
        .grant_active(gact)
    );

    always #5 clk = ~clk;

    // Source drivers and output monitor: inputs change on the falling
    // edge, handshakes for the coming rising edge are resolved at +1.
    initial begin
        obs_t o;
        for (int n = 0; n < 3; n++) begin
            sd[n] = '0;
            su[n] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                sv   = '0;
                hold = '0;
                continue;
            end
            for (int n = 0; n < 3; n++) begin
                if (!hold[n]) begin
                    if (sq[n].size() > 0 &&
                        int'($urandom_range(99)) < vprob) begin
                        sv[n]   = 1'b1;
                        sd[n]   = sq[n][0].d;
                        su[n]   = sq[n][0].u;
                        sl[n]   = sq[n][0].l;
                        hold[n] = 1'b1;
                    end else begin
                        sv[n] = 1'b0;
                    end
                end
            end
            case (m_mode)
                0:       mr = 1'b1;
                1:       mr = ~mr;
                default: mr = 1'($urandom_range(1));
            endcase
            #1;
            for (int n = 0; n < 3; n++) begin
                if (sv[n] && sr[n]) begin
                    void'(sq[n].pop_front());
                    hold[n] = 1'b0;
                end
            end
            if (mv && mr) begin
                o = '{d: md, u: mu, l: ml, t: mt};
                obs.push_back(o);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_pkt(int n, int len, logic [63:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = base + 64'(i);
            b.u = $urandom;
            b.l = (i == len - 1);
            sq[n].push_back(b);
            ref_q[n].push_back(b);
        end
    endtask

    // Model: move one whole packet of source n to the expected stream
    function automatic void take_pkt(int n);
        obs_t  e;
        beat_t b;
        do begin
            b = ref_q[n].pop_front();
            e = '{d: b.d, u: b.u, l: b.l, t: 2'(n)};
            exp_q.push_back(e);
        end while (!b.l && ref_q[n].size() > 0);
    endfunction

    // Model: every enabled source with packets waits continuously, so
    // packets leave in round-robin order starting after source 2.
    function automatic void rr_all(logic [2:0] mask);
        int  last = 2;
        int  c;
        logic any;
        do begin
            any = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                c = (last + k) % 3;
                if (!any && mask[c] && ref_q[c].size() > 0) begin
                    take_pkt(c);
                    last = c;
                    any  = 1'b1;
                end
            end
        end while (any);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int n = 0; n < 3; n++) begin
            sq[n].delete();
            ref_q[n].delete();
        end
        obs.delete();
        exp_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        tests++;
        if ({sr, mv, ml, mt, ovf, gact} !== 9'd0) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 0",
                     {sr, mv, ml, mt, ovf, gact});
        end
        tests++;
        if ({md, mu} !== 96'd0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {md, mu});
        end
        do_reset();
        tick();
        tests++;
        if ({sr, mv, gact} !== 5'd0) begin
            fails++;
            $display("FAIL reset_idle: got %b want 0", {sr, mv, gact});
        end
    endtask

    task automatic test_single();
        int k0 = -1;
        int k1 = -1;
        do_reset();
        en = 3'b111; vprob = 100; m_mode = 0;
        push_pkt(1, 4, 64'd1);
        rr_all(3'b111);
        for (int c = 0; c < 60 && obs.size() < 4; c++) begin
            tick();
            if (sv[1] && k0 < 0) k0 = c;
            if (mv && k1 < 0) k1 = c;
        end
        tests++;
        if (k1 - k0 != 2) begin
            fails++;
            $display("FAIL single_latency: got %0d want 2", k1 - k0);
        end
        tests++;
        if (obs.size() != 4) begin
            fails++;
            $display("FAIL single_count: got %0d want 4", obs.size());
        end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL single_beat%0d: got %h want %h",
                         i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 3'b111; vprob = 100; m_mode = 0;
        for (int p = 0; p < 2; p++)
            for (int n = 0; n < 3; n++)
                push_pkt(n, 2, {$urandom, $urandom});
        rr_all(3'b111);
        for (int c = 0; c < 200 && obs.size() < 12; c++) tick();
        tests++;
        if (obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rr_count: got %0d want %0d",
                     obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL rr_beat%0d: got %h want %h",
                         i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic pstall = 1'b0;
        obs_t pout;
        do_reset();
        en = 3'b111; vprob = 100; m_mode = 1;
        push_pkt(2, 8, {$urandom, $urandom});
        rr_all(3'b111);
        pout = '0;
        for (int c = 0; c < 200 && obs.size() < 8; c++) begin
            tick();
            if (pstall) begin
                tests++;
                if ({md, mu, ml, mt} !== pout) begin
                    fails++;
                    $display("FAIL stall_hold: got %h want %h",
                             {md, mu, ml, mt}, pout);
                end
            end
            if (mv && !mr) begin
                tests++;
                if (sr[2] !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_ready: got %b want 0", sr[2]);
                end
            end
            pstall = mv && !mr;
            pout   = {md, mu, ml, mt};
        end
        tests++;
        if (obs.size() != 8) begin
            fails++;
            $display("FAIL stall_count: got %0d want 8", obs.size());
        end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL stall_beat%0d: got %h want %h",
                         i, obs[i], exp_q[i]);
            end
        end
        m_mode = 0;
    endtask

    task automatic test_enable();
        do_reset();
        en = 3'b101; vprob = 100; m_mode = 0;
        push_pkt(1, 3, {$urandom, $urandom});
        push_pkt(0, 6, {$urandom, $urandom});
        push_pkt(2, 2, {$urandom, $urandom});
        take_pkt(0);
        take_pkt(2);
        for (int c = 0; c < 100 && obs.size() < 8; c++) begin
            tick();
            if (obs.size() >= 2) en = 3'b100;
            tests++;
            if (sr[1] !== 1'b0) begin
                fails++;
                $display("FAIL en_s1_ready: got %b want 0", sr[1]);
            end
        end
        repeat (10) tick();
        tests++;
        if (obs.size() != 8) begin
            fails++;
            $display("FAIL en_count: got %0d want 8", obs.size());
        end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL en_beat%0d: got %h want %h",
                         i, obs[i], exp_q[i]);
            end
        end
        en = 3'b111;
    endtask

    task automatic test_oversize();
        do_reset();
        en = 3'b111; vprob = 100; m_mode = 0;
        push_pkt(0, 35, {$urandom, $urandom});
        rr_all(3'b111);
        for (int c = 0; c < 100 && obs.size() < 35; c++) begin
            tick();
            tests++;
            if (ovf !== (obs.size() >= 34)) begin
                fails++;
                $display("FAIL ovf_at%0d: got %b want %b",
                         obs.size(), ovf, obs.size() >= 34);
            end
        end
        repeat (5) tick();
        tests++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got %b want 1", ovf);
        end
        tests++;
        if (obs.size() != 35) begin
            fails++;
            $display("FAIL ovf_count: got %0d want 35", obs.size());
        end
        for (int i = 0; i < 35 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL ovf_beat%0d: got %h want %h",
                         i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 3'b111; vprob = 100; m_mode = 0;
        push_pkt(0, 10, {$urandom, $urandom});
        for (int c = 0; c < 50 && obs.size() < 3; c++) tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({sr, mv, gact} !== 5'd0) begin
            fails++;
            $display("FAIL midrst_async: got %b want 0", {sr, mv, gact});
        end
        do_reset();
        push_pkt(2, 3, {$urandom, $urandom});
        push_pkt(0, 2, {$urandom, $urandom});
        rr_all(3'b111);
        for (int c = 0; c < 100 && obs.size() < 5; c++) tick();
        tests++;
        if (obs.size() != 5) begin
            fails++;
            $display("FAIL midrst_count: got %0d want 5", obs.size());
        end
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL midrst_beat%0d: got %h want %h",
                         i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int total = 0;
        int idx [3];
        int t;
        do_reset();
        en = 3'b111; vprob = 60; m_mode = 2;
        for (int n = 0; n < 3; n++) begin
            idx[n] = 0;
            for (int p = 0; p < 4; p++) begin
                t = 1 + int'($urandom_range(4));
                total += t;
                push_pkt(n, t, {$urandom, $urandom});
            end
        end
        for (int c = 0; c < 3000 && obs.size() < total; c++) tick();
        tests++;
        if (obs.size() != total) begin
            fails++;
            $display("FAIL rand_count: got %0d want %0d",
                     obs.size(), total);
        end
        for (int i = 0; i < obs.size(); i++) begin
            t = int'(obs[i].t);
            tests++;
            if (t > 2 || idx[t] >= ref_q[t].size()) begin
                fails++;
                $display("FAIL rand_tid%0d: got %0d want 0..2", i, t);
            end else begin
                if ({obs[i].d, obs[i].u, obs[i].l} !== ref_q[t][idx[t]])
                begin
                    fails++;
                    $display("FAIL rand_beat%0d: got %h want %h", i,
                             {obs[i].d, obs[i].u, obs[i].l},
                             ref_q[t][idx[t]]);
                end
                idx[t]++;
            end
            if (i > 0 && !obs[i-1].l) begin
                tests++;
                if (obs[i].t !== obs[i-1].t) begin
                    fails++;
                    $display("FAIL rand_interleave%0d: got %0d want %0d",
                             i, obs[i].t, obs[i-1].t);
                end
            end
        end
        vprob = 100;
        m_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_stall();
        test_enable();
        test_oversize();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
